// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = MDU_WIDTH;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;
endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; yields |x| when neg_i = sign bit.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);
    assign y_o = neg_i ? (~x_i + 1'b1) : x_i;
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU on magnitudes with HI/LO result registers.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MDU_ITER);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning: unsigned ops never see a sign flag.
    logic             sa, sb, rt_zero;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign sa      = ~op[0] & rs_data[WIDTH-1];
    assign sb      = ~op[0] & rt_data[WIDTH-1];
    assign rt_zero = (rt_data == '0);

    mdu_abs_neg #(.W(WIDTH)) u_abs_a (.x_i(rs_data), .neg_i(sa), .y_o(abs_a));
    mdu_abs_neg #(.W(WIDTH)) u_abs_b (.x_i(rt_data), .neg_i(sb), .y_o(abs_b));

    // Shift-add step: upper half accumulates, multiplier bits shift out the bottom.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nx;
    assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    assign mul_nx = {msum, acc_q[WIDTH-1:1]};

    // Restoring step: remainder in the upper half, quotient bits shift into the lower half.
    logic [WIDTH:0]     rem, trial;
    logic               qbit;
    logic [WIDTH-1:0]   rnew;
    logic [2*WIDTH-1:0] div_nx;
    assign rem    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial  = rem - {1'b0, b_q};
    assign qbit   = ~trial[WIDTH];
    assign rnew   = qbit ? trial[WIDTH-1:0] : rem[WIDTH-1:0];
    assign div_nx = {rnew, acc_q[WIDTH-2:0], qbit};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    mdu_abs_neg #(.W(2*WIDTH)) u_fix_p (.x_i(acc_q), .neg_i(negq_q), .y_o(prod_fix));
    mdu_abs_neg #(.W(WIDTH)) u_fix_q (.x_i(acc_q[WIDTH-1:0]), .neg_i(negq_q), .y_o(quo_fix));
    mdu_abs_neg #(.W(WIDTH)) u_fix_r (.x_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(negr_q), .y_o(rem_fix));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    b_d      = abs_b;
                    is_div_d = op[1];
                    // Divide by zero keeps the all-ones quotient regardless of signs.
                    negq_d   = (sa ^ sb) & ~(op[1] & rt_zero);
                    negr_d   = sa;
                end else begin
                    if (mthi) hi_d = rs_data;
                    if (mtlo) lo_d = rs_data;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_nx : mul_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MDU_ITER - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
